// File: rtl/dma_sound_fifo.sv
// DMA-sound playback engine: occupancy-counted sample FIFO, replay-rate pacing and
// offset-binary left/right output. Define DMA_SOUND_16BIT_EN to add the 16-bit sample modes.
module dma_sound_fifo #(
  parameter int FIFO_ADDR_BITS = 3,
  parameter int CLK_DIV        = 640,
  parameter int SREQ_SLACK     = 1
) (
  input  logic                      clk32,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [3:0]                sndmode,
  input  logic                      sload_n,
  input  logic [15:0]               mdin,
  output logic                      sreq,
  output logic [FIFO_ADDR_BITS:0]   level,
  output logic                      sample_tick,
  output logic                      overflow,
  output logic                      underrun,
  output logic [15:0]               audio_left,
  output logic [15:0]               audio_right
);

  localparam int AW    = FIFO_ADDR_BITS;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [AW:0]   DEPTH_V  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   SLACK_V  = (AW+1)'(SREQ_SLACK);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          sload_d;
  logic          wr_fire, full, push;
  logic          mono, wide;
  logic          bytesel;

  logic [CW-1:0] base_cnt;
  logic          base_en;
  logic [2:0]    aclk_cnt;
  logic          tick_req;
  logic          rate_hit;

  logic [15:0]   w0;
  logic [7:0]    mono_byte;
  logic          data_ok, do_pop, nxt_bytesel;
  logic [1:0]    pop_cnt, pop_n;
  logic [15:0]   nxt_left, nxt_right;

  assign mono = sndmode[2];
`ifdef DMA_SOUND_16BIT_EN
  logic [15:0] w1;
  assign wide = sndmode[3];
  assign w1   = mem[rd_ptr + AW'(1)];
`else
  logic unused_mode;
  assign wide        = 1'b0;
  assign unused_mode = sndmode[3];
`endif

  assign wr_fire = sload_n & ~sload_d;
  assign full    = (level == DEPTH_V);
  assign push    = wr_fire & ~full;

  always_comb sreq = (DEPTH_V - level) > SLACK_V;

  always_comb begin
    case (sndmode[1:0])
      2'b11:   rate_hit = 1'b1;
      2'b10:   rate_hit = ~aclk_cnt[0];
      2'b01:   rate_hit = (aclk_cnt[1:0] == 2'b00);
      default: rate_hit = (aclk_cnt == 3'b000);
    endcase
  end

  // Sample selection for the current tick; only applied when do_pop is set.
  always_comb begin
    w0          = mem[rd_ptr];
    mono_byte   = bytesel ? w0[7:0] : w0[15:8];
    data_ok     = 1'b0;
    pop_cnt     = 2'd0;
    nxt_left    = audio_left;
    nxt_right   = audio_right;
    nxt_bytesel = bytesel;
`ifdef DMA_SOUND_16BIT_EN
    if (wide) begin
      if (mono) begin
        data_ok   = (level != '0);
        nxt_left  = w0 ^ 16'h8000;
        nxt_right = w0 ^ 16'h8000;
        pop_cnt   = 2'd1;
      end else begin
        data_ok   = (level >= (AW+1)'(2));
        nxt_left  = w0 ^ 16'h8000;
        nxt_right = w1 ^ 16'h8000;
        pop_cnt   = 2'd2;
      end
    end else
`endif
    if (mono) begin
      data_ok     = (level != '0);
      nxt_left    = {mono_byte ^ 8'h80, 8'h00};
      nxt_right   = {mono_byte ^ 8'h80, 8'h00};
      pop_cnt     = bytesel ? 2'd1 : 2'd0;
      nxt_bytesel = ~bytesel;
    end else begin
      data_ok   = (level != '0);
      nxt_left  = {w0[15:8] ^ 8'h80, 8'h00};
      nxt_right = {w0[7:0] ^ 8'h80, 8'h00};
      pop_cnt   = 2'd1;
    end
  end

  assign do_pop = enable & tick_req & data_ok;
  assign pop_n  = do_pop ? pop_cnt : 2'd0;

  always_ff @(posedge clk32) begin
    if (push && !reset) mem[wr_ptr] <= mdin;
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      // sload_d starts high so a strobe already low across reset needs a fresh rising edge.
      sload_d     <= 1'b1;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      base_cnt    <= '0;
      base_en     <= 1'b0;
      aclk_cnt    <= 3'd0;
      tick_req    <= 1'b0;
      bytesel     <= 1'b0;
      sample_tick <= 1'b0;
      overflow    <= 1'b0;
      underrun    <= 1'b0;
      audio_left  <= 16'h8000;
      audio_right <= 16'h8000;
    end else begin
      sload_d     <= sload_n;
      base_cnt    <= (base_cnt == CNT_LAST) ? '0 : base_cnt + CW'(1);
      base_en     <= (base_cnt == '0);
      if (base_en) aclk_cnt <= aclk_cnt + 3'd1;
      tick_req    <= base_en & rate_hit;
      overflow    <= wr_fire & full;
      sample_tick <= do_pop;
      underrun    <= enable & tick_req & ~data_ok;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (!enable) begin
        // Flush tracks the write pointer so a word landing now is not misaligned later.
        rd_ptr      <= push ? wr_ptr + AW'(1) : wr_ptr;
        level       <= '0;
        bytesel     <= 1'b0;
        audio_left  <= 16'h8000;
        audio_right <= 16'h8000;
      end else begin
        level  <= level + (AW+1)'(push) - (AW+1)'(pop_n);
        rd_ptr <= rd_ptr + AW'(pop_n);
        if (do_pop) begin
          audio_left  <= nxt_left;
          audio_right <= nxt_right;
        end
        bytesel <= (mono & ~wide) ? (do_pop ? nxt_bytesel : bytesel) : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dma_sound_fifo.sv
// Directed bench for dma_sound_fifo: fill/overflow, pacing, stereo/mono decode,
// underrun, flush, simultaneous push/pop and (with DMA_SOUND_16BIT_EN) 16-bit stereo.
module tb_dma_sound_fifo;

  logic        clk32 = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  sndmode;
  logic        sload_n;
  logic [15:0] mdin;
  logic        sreq;
  logic [3:0]  level;
  logic        sample_tick, overflow, underrun;
  logic [15:0] audio_left, audio_right;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [15:0] mono_exp [4] = '{16'h8100, 16'h8200, 16'h8300, 16'h8400};
  int          mono_lvl [4] = '{2, 1, 1, 0};

  dma_sound_fifo dut (
    .clk32(clk32), .reset(reset), .enable(enable), .sndmode(sndmode),
    .sload_n(sload_n), .mdin(mdin), .sreq(sreq), .level(level),
    .sample_tick(sample_tick), .overflow(overflow), .underrun(underrun),
    .audio_left(audio_left), .audio_right(audio_right)
  );

  always #5 clk32 = ~clk32;
  always @(posedge clk32) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Low for one cycle, then high; the write lands on the following edge.
  task automatic push(input logic [15:0] w);
    mdin    = w;
    sload_n = 1'b0;
    @(posedge clk32); #1;
    sload_n = 1'b1;
    @(posedge clk32); #1;
  endtask

  // kind: 1 = sample_tick, 2 = underrun, 0 = bound expired.
  task automatic wait_evt(input int bound, output int kind, output int t);
    kind = 0;
    t    = 0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk32); #1;
      if (sample_tick) begin kind = 1; t = cyc; break; end
      if (underrun)    begin kind = 2; t = cyc; break; end
    end
  endtask

  initial begin
    int k, t0, t1, t2;
    reset   = 1'b1;
    enable  = 1'b1;
    sndmode = 4'b0000;
    sload_n = 1'b0;
    mdin    = 16'h0;
    repeat (3) @(posedge clk32);
    #1;
    check("rst_level", level, 0);
    check("rst_sreq", sreq, 1);
    check("rst_left", audio_left, 16'h8000);
    check("rst_right", audio_right, 16'h8000);
    check("rst_pulses", {sample_tick, overflow, underrun}, 0);

    reset   = 1'b0;
    sload_n = 1'b1;
    wait_evt(6000, k, t0);
    check("first_underrun", k, 2);
    check("no_stale_write", level, 0);

    for (int i = 1; i <= 8; i++) begin
      push(16'h1000 + 16'(i));
      check("fill_level", level, i);
      if (i == 6) check("sreq_at6", sreq, 1);
      if (i == 7) check("sreq_at7", sreq, 0);
    end
    push(16'hDEAD);
    check("ovf_pulse", overflow, 1);
    check("ovf_level", level, 8);

    enable = 1'b0;
    @(posedge clk32); #1;
    check("flush_level", level, 0);
    sndmode = 4'b0011;
    enable  = 1'b1;
    wait_evt(700, k, t0);
    check("sync11", k, 2);
    push(16'h7F80);
    wait_evt(700, k, t1);
    check("st_kind", k, 1);
    check("st_left", audio_left, 16'hFF00);
    check("st_right", audio_right, 16'h0000);
    check("st_level", level, 0);
    push(16'h0102);
    wait_evt(700, k, t2);
    check("st2_kind", k, 1);
    check("spacing_50k", t2 - t1, 640);
    check("st2_left", audio_left, 16'h8100);
    check("st2_right", audio_right, 16'h8200);

    sndmode = 4'b0000;
    wait_evt(6000, k, t1);
    check("r00_first", k, 2);
    wait_evt(6000, k, t2);
    check("r00_second", k, 2);
    check("spacing_6k25", t2 - t1, 5120);

    sndmode = 4'b0111;
    wait_evt(6000, k, t0);
    check("mono_sync", k, 2);
    push(16'h0102);
    push(16'h0304);
    check("mono_fill", level, 2);
    for (int i = 0; i < 4; i++) begin
      wait_evt(700, k, t0);
      check("mono_kind", k, 1);
      check("mono_left", audio_left, mono_exp[i]);
      check("mono_right", audio_right, mono_exp[i]);
      check("mono_level", level, mono_lvl[i]);
    end
    wait_evt(700, k, t0);
    check("udr_kind", k, 2);
    check("udr_hold_l", audio_left, 16'h8400);
    check("udr_hold_r", audio_right, 16'h8400);

    sndmode = 4'b0011;
    for (int i = 0; i < 5; i++) push(16'h2000 + 16'(i));
    check("pre_dis_level", level, 5);
    enable = 1'b0;
    @(posedge clk32); #1;
    check("dis_level", level, 0);
    check("dis_left", audio_left, 16'h8000);
    check("dis_right", audio_right, 16'h8000);
    check("dis_sreq", sreq, 1);

    enable = 1'b1;
    wait_evt(700, k, t0);
    check("sim_sync", k, 2);
    for (int i = 0; i < 3; i++) push(16'h7F80);
    check("sim_pre", level, 3);
    while (cyc < t0 + 638) begin @(posedge clk32); #1; end
    push(16'h3333);
    check("sim_tick", sample_tick, 1);
    check("sim_level3", level, 3);
    check("sim_no_ovf", overflow, 0);
    t1 = cyc;
    for (int i = 0; i < 5; i++) push(16'h4444);
    check("sim_full", level, 8);
    while (cyc < t1 + 638) begin @(posedge clk32); #1; end
    push(16'h5555);
    check("simf_tick", sample_tick, 1);
    check("simf_ovf", overflow, 1);
    check("simf_level", level, 7);

`ifdef DMA_SOUND_16BIT_EN
    enable = 1'b0;
    @(posedge clk32); #1;
    sndmode = 4'b1011;
    enable  = 1'b1;
    wait_evt(700, k, t0);
    check("w16_sync", k, 2);
    push(16'h1234);
    push(16'hFEDC);
    wait_evt(700, k, t0);
    check("w16_kind", k, 1);
    check("w16_left", audio_left, 16'h9234);
    check("w16_right", audio_right, 16'h7EDC);
    check("w16_level", level, 0);
    push(16'h5555);
    wait_evt(700, k, t0);
    check("w16_udr", k, 2);
    check("w16_udr_level", level, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
